sevseg_scan_driver: RTL
=======================

Name: sevseg_scan_driver

Overview:
- Parametrised time-multiplexed seven-segment display driver for NUM_DIGITS common-anode or common-cathode digits.
- Built-in hex decoder, per-digit decimal point and enable, and leading-zero blanking.
- Anti-ghosting dead time at each digit switch, plus 16-level brightness by duty-cycle gating.
- Sits between counter/debounce logic and the board pins; the board SEG/DIGIT pins are driven directly from registers.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits, 2..8.
- CLK_DIV, 50000: CLK cycles per digit slot. Requires CLK_DIV >= DEAD_CYCLES+16.
- DEAD_CYCLES, 500: cycles at the start of each slot with all digits off.
- SEG_ACTIVE_LOW, 1: SEG pin polarity (1 = segment lit when 0).
- DIG_ACTIVE_LOW, 1: DIGIT pin polarity (1 = digit selected when 0).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- DIGITS_IN  in  4*NUM_DIGITS  hex nibbles; nibble i = digit i, digit 0 = rightmost.
- DP_IN  in  NUM_DIGITS  decimal point request per digit.
- ENA_IN  in  NUM_DIGITS  per-digit enable (0 = digit always dark).
- BLANK_LZ  in  1  leading-zero blanking enable.
- BRIGHT  in  4  brightness; 0 = off, 15 = full.
- SEG  out  8  SEG[7] = dp, SEG[6:0] = g..a.
- DIGIT  out  NUM_DIGITS  one-hot digit select, after polarity.
- FRAME_TICK  out  1  one-cycle pulse when a new input snapshot is taken.

Behaviour:
- Reset, applied asynchronously:
  - prescaler p = 0, slot index posn = 0, snapshot-valid flag sv = 0, shadow registers cleared.
  - SEG = all segments off: 8'hFF if SEG_ACTIVE_LOW, else 8'h00.
  - DIGIT = all digits off, same polarity rule.
  - FRAME_TICK = 0.
- Prescaler:
  - p counts 0..CLK_DIV-1 and wraps.
  - On the cycle p == CLK_DIV-1, posn advances; it wraps from NUM_DIGITS-1 to 0.
- Snapshot:
  - Occurs on the cycle p == CLK_DIV-1 and posn == NUM_DIGITS-1.
  - DIGITS_IN, DP_IN, ENA_IN, BLANK_LZ and BRIGHT are latched into shadow registers, sv is set to 1, and FRAME_TICK pulses on the next cycle.
  - Display uses only shadow values, so no tearing within a frame.
  - Until the first snapshot (sv = 0) the display is dark.
- Window:
  - localparam STEP = (CLK_DIV-DEAD_CYCLES)/16.
  - on_end = CLK_DIV if BRIGHT == 15, else DEAD_CYCLES + BRIGHT*STEP.
  - The window is active when DEAD_CYCLES <= p < on_end.
- Leading-zero blanking: digit i > 0 is blanked when all of the following hold:
  - shadow BLANK_LZ = 1;
  - nibbles i..NUM_DIGITS-1 are all 0;
  - DP for digit i is 0.
  - Digit 0 is never blanked by this rule.
- Show condition: sv && window && ENA[posn] && !blanked(posn).
- Registered outputs, one cycle after the p/posn state that produced them:
  - Show condition true:
    - DIGIT has only bit posn selected.
    - SEG[6:0] = decode(nibble posn).
    - SEG[7] = DP[posn].
    - Both are polarity-applied.
  - Show condition false: DIGIT all off and SEG all off.
- Decode, active-high gfedcba:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Dead time guarantees DIGIT is all-off for at least DEAD_CYCLES between consecutive selects, including the posn wrap.
- Reset mid-frame: outputs go dark immediately and asynchronously. The first post-reset frame is dark (sv = 0).
- Inputs may change at any time; a change is visible only after the next snapshot.

Decomposition:
- Shared package sevseg_pkg:
  - 16-entry hex-to-segment constant table.
  - SEG_OFF / DIG_OFF polarity helpers.
  - Bit index constants for dp.
- One combinational sub-module, hex_to_sevseg: 4-bit in, 7-bit active-high out.

Test Plan:
Bench configuration: NUM_DIGITS=4, CLK_DIV=20, DEAD_CYCLES=4, so STEP=1.
1. Reset release, DIGITS_IN=16'h1234, BRIGHT=15, ENA=4'hF:
   - First 80 cycles: DIGIT=4'hF, SEG=8'hFF.
   - FRAME_TICK pulses once at cycle 80.
   - Next frame, slot 0: DIGIT=4'b1110, SEG=~8'h66 (digit 4) for 16 cycles after 4 dark cycles.
2. Leading-zero blanking: DIGITS_IN=16'h0050, BLANK_LZ=1.
   - Slots 3 and 2 are dark; slot 1 shows 5 (SEG=~8'h6D); slot 0 shows 0 (~8'h3F).
   - Same input with DP_IN=4'b0100: slot 2 shows 0 with dp (SEG=~8'hBF).
3. Brightness: BRIGHT=0 gives no digit selected in a full frame. BRIGHT=8 gives the selected digit for exactly 8 cycles per slot (p=4..11).
4. Snapshot coherence: change DIGITS_IN from 16'h1111 to 16'h2222 mid-frame (posn=1).
   - Slots 1..3 still show 1.
   - All slots show 2 starting with the frame after the next FRAME_TICK.
5. Enable and polarity: ENA=4'b1010 leaves slots 0 and 2 dark. A second build with SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=0 drives SEG=8'h06 for digit 1 and DIGIT=4'b0001 for slot 0.
6. Async reset asserted mid-slot while a digit is lit: DIGIT and SEG go to off in the same cycle with no clock edge, and p and posn restart at 0.

Source files
------------

// File: rtl/sevseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sevseg_pkg
//  Description : Shared constants and helpers for the seven-segment scan
//                driver: hex-to-segment table, segment bit positions and
//                pin-polarity helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package sevseg_pkg;

    // Segment bus layout: bit 7 is the decimal point, bits 6..0 are g..a.
    localparam int c_seg_dp_bit  = 7;
    localparam int c_seg_msb_bit = 6;

    // Active-high gfedcba patterns for hex digits 0..F.
    localparam logic [6:0] c_hex_seg_table [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Segment pattern that lights nothing for the given pin polarity. The
    // same value doubles as the XOR mask that converts active-high to pins.
    function automatic logic [7:0] seg_off(input bit active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

    // Digit-select pattern (up to 8 digits) that selects nothing.
    function automatic logic [7:0] dig_off(input bit active_low);
        return active_low ? 8'hFF : 8'h00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sevseg_scan_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : sevseg_scan_driver_if
//  Description : Display-data bus between the value producer (master) and
//                the scan driver (slave), plus the board-facing pin outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sevseg_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] DIGITS_IN;
    logic [NUM_DIGITS-1:0]   DP_IN;
    logic [NUM_DIGITS-1:0]   ENA_IN;
    logic                    BLANK_LZ;
    logic [3:0]              BRIGHT;
    logic [7:0]              SEG;
    logic [NUM_DIGITS-1:0]   DIGIT;
    logic                    FRAME_TICK;

    modport master (
        output DIGITS_IN, DP_IN, ENA_IN, BLANK_LZ, BRIGHT,
        input  SEG, DIGIT, FRAME_TICK
    );

    modport slave (
        input  DIGITS_IN, DP_IN, ENA_IN, BLANK_LZ, BRIGHT,
        output SEG, DIGIT, FRAME_TICK
    );
endinterface
`default_nettype wire

// File: rtl/hex_to_sevseg.sv
`default_nettype none
// ============================================================================
//  Module      : hex_to_sevseg
//  Description : Combinational hex nibble to active-high gfedcba decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module hex_to_sevseg
    import sevseg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    // Straight table lookup; polarity is applied by the caller.
    assign o_seg = c_hex_seg_table[i_hex];

endmodule
`default_nettype wire

// File: rtl/sevseg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sevseg_scan_driver
//  Description : Time-multiplexed seven-segment driver with frame snapshot,
//                anti-ghosting dead time, duty-cycle brightness, per-digit
//                enable/decimal point and leading-zero blanking. Pin outputs
//                come straight from registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int DEAD_CYCLES    = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    sevseg_scan_driver_if.slave  bus
);

    localparam int c_p_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_posn_w = $clog2(NUM_DIGITS);
    localparam int c_step   = (CLK_DIV - DEAD_CYCLES) / 16;

    localparam logic [c_p_w-1:0]    c_p_last    = c_p_w'(CLK_DIV - 1);
    localparam logic [c_posn_w-1:0] c_posn_last = c_posn_w'(NUM_DIGITS - 1);

    // Off patterns are also the XOR masks from active-high to pin polarity.
    localparam logic [7:0]            c_seg_off = seg_off(SEG_ACTIVE_LOW);
    localparam logic [NUM_DIGITS-1:0] c_dig_off = NUM_DIGITS'(dig_off(DIG_ACTIVE_LOW));

    // Scan timing state
    logic [c_p_w-1:0]    r_p;
    logic [c_posn_w-1:0] r_posn;

    // Frame shadow registers; the display reads only these
    logic                    r_sv;
    logic [4*NUM_DIGITS-1:0] r_digits_sh;
    logic [NUM_DIGITS-1:0]   r_dp_sh;
    logic [NUM_DIGITS-1:0]   r_ena_sh;
    logic                    r_blz_sh;
    logic [3:0]              r_bright_sh;

    // Registered pin outputs
    logic                  r_frame_tick;
    logic [7:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_digit;

    // Combinational helpers
    logic                  w_p_last;
    logic                  w_snapshot;
    int                    w_on_end;
    logic                  w_window;
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_show;
    logic [3:0]            w_nibble;
    logic [6:0]            w_seg7;
    logic [7:0]            w_seg_ah;
    logic [NUM_DIGITS-1:0] w_onehot;

    assign w_p_last   = (r_p == c_p_last);
    assign w_snapshot = w_p_last && (r_posn == c_posn_last);

    // Prescaler and slot index: p wraps every CLK_DIV cycles, posn advances on the wrap
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_p    <= '0;
            r_posn <= '0;
        end else if (w_p_last) begin
            r_p    <= '0;
            r_posn <= (r_posn == c_posn_last) ? '0 : r_posn + 1'b1;
        end else begin
            r_p    <= r_p + 1'b1;
        end
    end

    // Capture all display inputs at the end of the last slot so a frame never tears
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sv         <= 1'b0;
            r_digits_sh  <= '0;
            r_dp_sh      <= '0;
            r_ena_sh     <= '0;
            r_blz_sh     <= 1'b0;
            r_bright_sh  <= 4'h0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_snapshot;
            if (w_snapshot) begin
                r_sv        <= 1'b1;
                r_digits_sh <= bus.DIGITS_IN;
                r_dp_sh     <= bus.DP_IN;
                r_ena_sh    <= bus.ENA_IN;
                r_blz_sh    <= bus.BLANK_LZ;
                r_bright_sh <= bus.BRIGHT;
            end
        end
    end

    // Lit window inside a slot: starts after the dead time, length scales with brightness
    always_comb begin
        w_on_end = (r_bright_sh == 4'hF) ? CLK_DIV
                                         : DEAD_CYCLES + int'(r_bright_sh) * c_step;
        w_window = (int'(r_p) >= DEAD_CYCLES) && (int'(r_p) < w_on_end);
    end

    // Leading-zero blanking: a digit is blank when it and every digit to its left
    // are zero and it has no decimal point; the rightmost digit always shows.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign w_blank[gi] = 1'b0;
            end else begin : g_upper
                assign w_blank[gi] = r_blz_sh && !r_dp_sh[gi]
                                  && (r_digits_sh[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    assign w_nibble = r_digits_sh[{r_posn, 2'b00} +: 4];

    hex_to_sevseg u_hex (
        .i_hex (w_nibble),
        .o_seg (w_seg7)
    );

    // Active-high segment word and one-hot digit select for the current slot
    always_comb begin
        w_seg_ah                         = 8'h00;
        w_seg_ah[c_seg_dp_bit]           = r_dp_sh[r_posn];
        w_seg_ah[c_seg_msb_bit:0]        = w_seg7;
        w_onehot                         = '0;
        w_onehot[r_posn]                 = 1'b1;
    end

    assign w_show = r_sv && w_window && r_ena_sh[r_posn] && !w_blank[r_posn];

    // Pin registers: drive the selected digit during the window, otherwise all dark
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_seg   <= c_seg_off;
            r_digit <= c_dig_off;
        end else if (w_show) begin
            r_seg   <= w_seg_ah ^ c_seg_off;
            r_digit <= w_onehot ^ c_dig_off;
        end else begin
            r_seg   <= c_seg_off;
            r_digit <= c_dig_off;
        end
    end

    assign bus.SEG        = r_seg;
    assign bus.DIGIT      = r_digit;
    assign bus.FRAME_TICK = r_frame_tick;

endmodule
`default_nettype wire
